// File: rtl/bram_fifo_ctrl.sv
// FIFO controller in front of a dual-port BRAM (port A writes, port B reads)
// with a two-entry prefetch stage that gives a first-word-fall-through pop side.
// Optional macro BRAM_FIFO_BYPASS_EN: pushes into an otherwise empty pipeline
// skip the BRAM and land directly in the prefetch buffer.
module bram_fifo_ctrl #(
  parameter int DATA_WIDTH = 32,
  parameter int N_ENTRIES  = 128,
  localparam int AW        = $clog2(N_ENTRIES)
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  s_valid_i,
  input  logic [DATA_WIDTH-1:0] s_data_i,
  output logic                  s_ready_o,
  output logic                  m_valid_o,
  output logic [DATA_WIDTH-1:0] m_data_o,
  input  logic                  m_ready_i,
  output logic [AW:0]           count_o,
  output logic                  ram_en_o,
  output logic                  ram_a_we_o,
  output logic [AW-1:0]         ram_a_addr_o,
  output logic [DATA_WIDTH-1:0] ram_a_data_o,
  output logic                  ram_b_we_o,
  output logic [AW-1:0]         ram_b_addr_o,
  input  logic [DATA_WIDTH-1:0] ram_b_data_i
);

  localparam logic [AW:0] FULL_CNT = (AW+1)'(N_ENTRIES);

  logic [AW-1:0]         wr_ptr;
  logic [AW-1:0]         rd_ptr;
  logic [AW:0]           ram_cnt;
  logic [AW:0]           count;
  logic                  rd_inflight;
  logic [1:0]            pf_cnt;
  logic [1:0]            pf_cnt_nxt;
  logic [DATA_WIDTH-1:0] head;
  logic [DATA_WIDTH-1:0] skid;
  logic [DATA_WIDTH-1:0] head_nxt;
  logic [DATA_WIDTH-1:0] skid_nxt;
  logic                  push;
  logic                  pop;
  logic                  rd_issue;
  logic                  bypass;
  logic                  fill;
  logic [DATA_WIDTH-1:0] fill_data;
  logic [2:0]            pf_committed;

  assign s_ready_o = (count < FULL_CNT);
  assign m_valid_o = (pf_cnt != 2'd0);
  assign m_data_o  = head;
  assign count_o   = count;

  assign push = s_valid_i & s_ready_o;
  assign pop  = m_valid_o & m_ready_i;

  // Prefetch slots already spoken for after this cycle's pop; a new read may
  // only be issued if its data is guaranteed a free slot when it returns.
  assign pf_committed = {1'b0, pf_cnt} + {2'b0, rd_inflight} - {2'b0, pop};
  assign rd_issue     = (ram_cnt != '0) && (pf_committed < 3'd2);

`ifdef BRAM_FIFO_BYPASS_EN
  assign bypass    = push && (ram_cnt == '0) && !rd_inflight &&
                     (({1'b0, pf_cnt} - {2'b0, pop}) < 3'd2);
  assign fill      = rd_inflight | bypass;
  assign fill_data = rd_inflight ? ram_b_data_i : s_data_i;
`else
  assign bypass    = 1'b0;
  assign fill      = rd_inflight;
  assign fill_data = ram_b_data_i;
`endif

  assign ram_en_o     = 1'b1;
  assign ram_a_we_o   = push & ~bypass;
  assign ram_a_addr_o = wr_ptr;
  assign ram_a_data_o = s_data_i;
  assign ram_b_we_o   = 1'b0;
  assign ram_b_addr_o = rd_ptr;

  // Pop first so the skid entry moves up, then drop returning data into the
  // first free slot to keep strict FIFO order.
  always_comb begin
    head_nxt   = head;
    skid_nxt   = skid;
    pf_cnt_nxt = pf_cnt;
    if (pop) begin
      head_nxt   = skid;
      pf_cnt_nxt = pf_cnt - 2'd1;
    end
    if (fill) begin
      if (pf_cnt_nxt == 2'd0) begin
        head_nxt = fill_data;
      end else begin
        skid_nxt = fill_data;
      end
      pf_cnt_nxt = pf_cnt_nxt + 2'd1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      ram_cnt     <= '0;
      count       <= '0;
      rd_inflight <= 1'b0;
      pf_cnt      <= 2'd0;
      head        <= '0;
      skid        <= '0;
    end else begin
      if (ram_a_we_o) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (rd_issue) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      ram_cnt     <= ram_cnt + {{AW{1'b0}}, ram_a_we_o} - {{AW{1'b0}}, rd_issue};
      count       <= count + {{AW{1'b0}}, push} - {{AW{1'b0}}, pop};
      rd_inflight <= rd_issue;
      pf_cnt      <= pf_cnt_nxt;
      head        <= head_nxt;
      skid        <= skid_nxt;
    end
  end

endmodule

// File: tb/tb_bram_fifo_ctrl.sv
// Self-checking bench for bram_fifo_ctrl: a behavioural BRAM, a queue-based
// reference model, a timing vector table and directed/random sequences.
module tb_bram_fifo_ctrl;

  localparam int DW = 32;
  localparam int N  = 128;
  localparam int AW = 7;

  logic          clk = 1'b0;
  logic          rst_i;
  logic          s_valid_i;
  logic [DW-1:0] s_data_i;
  logic          s_ready_o;
  logic          m_valid_o;
  logic [DW-1:0] m_data_o;
  logic          m_ready_i;
  logic [AW:0]   count_o;
  logic          ram_en_o;
  logic          ram_a_we_o;
  logic [AW-1:0] ram_a_addr_o;
  logic [DW-1:0] ram_a_data_o;
  logic          ram_b_we_o;
  logic [AW-1:0] ram_b_addr_o;
  logic [DW-1:0] ram_b_data_i;

  logic [DW-1:0] mem [N];

  always #5 clk = ~clk;

  bram_fifo_ctrl #(.DATA_WIDTH(DW), .N_ENTRIES(N)) dut (
    .clk_i(clk), .rst_i(rst_i),
    .s_valid_i(s_valid_i), .s_data_i(s_data_i), .s_ready_o(s_ready_o),
    .m_valid_o(m_valid_o), .m_data_o(m_data_o), .m_ready_i(m_ready_i),
    .count_o(count_o), .ram_en_o(ram_en_o),
    .ram_a_we_o(ram_a_we_o), .ram_a_addr_o(ram_a_addr_o), .ram_a_data_o(ram_a_data_o),
    .ram_b_we_o(ram_b_we_o), .ram_b_addr_o(ram_b_addr_o), .ram_b_data_i(ram_b_data_i)
  );

  // Dual-port BRAM with registered read and read-old-data on collision.
  always @(posedge clk) begin
    if (ram_en_o) begin
      ram_b_data_i <= mem[ram_b_addr_o];
      if (ram_a_we_o) mem[ram_a_addr_o] <= ram_a_data_o;
    end
  end

  int n_checks = 0;
  int n_fail   = 0;
  int push_total = 0;
  int pop_total  = 0;
  logic [DW-1:0] model_q[$];

  typedef struct {
    logic          sv;
    logic [DW-1:0] sd;
    logic          mr;
    logic          exp_mv;
    logic [DW-1:0] exp_data;
    int            exp_count;
  } vec_t;

  vec_t vecs[12];

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // One clock of stimulus; the model decides push/pop from pre-edge state,
  // then the post-edge outputs are compared against the updated queue.
  task automatic applyStimulus(input logic sv, input logic [DW-1:0] sd, input logic mr);
    logic exp_push;
    logic exp_pop;
    s_valid_i = sv;
    s_data_i  = sd;
    m_ready_i = mr;
    #1;
    exp_push = sv && (model_q.size() < N);
    exp_pop  = mr && m_valid_o;
    checkOutput("ram_a_we", ram_a_we_o, exp_push);
    if (exp_push) checkOutput("ram_a_addr", ram_a_addr_o, push_total % N);
    @(posedge clk);
    #1;
    if (exp_pop) begin
      checkOutput("pop_nonempty", model_q.size() > 0, 1);
      if (model_q.size() > 0) begin
        void'(model_q.pop_front());
        pop_total++;
      end
    end
    if (exp_push) begin
      model_q.push_back(sd);
      push_total++;
    end
    checkOutput("count", count_o, model_q.size());
    checkOutput("s_ready", s_ready_o, model_q.size() < N);
    if (model_q.size() == 0) checkOutput("m_valid_empty", m_valid_o, 0);
    else if (m_valid_o) checkOutput("m_data", m_data_o, model_q[0]);
  endtask

  task automatic doReset();
    rst_i = 1'b1;
    s_valid_i = 1'b0;
    m_ready_i = 1'b0;
    @(posedge clk);
    #1;
    rst_i = 1'b0;
    model_q.delete();
    push_total = 0;
    pop_total  = 0;
  endtask

  task automatic drain(input string name);
    for (int i = 0; i < 400 && model_q.size() > 0; i++) applyStimulus(1'b0, '0, 1'b1);
    checkOutput(name, model_q.size(), 0);
  endtask

  initial begin
    #2_000_000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    rst_i = 1'b1;
    s_valid_i = 1'b0;
    s_data_i = '0;
    m_ready_i = 1'b0;
    repeat (2) @(posedge clk);
    doReset();

    checkOutput("rst_count", count_o, 0);
    checkOutput("rst_m_valid", m_valid_o, 0);
    checkOutput("rst_m_data", m_data_o, 0);
    checkOutput("rst_s_ready", s_ready_o, 1);
    checkOutput("rst_ram_en", ram_en_o, 1);
    checkOutput("rst_ram_b_we", ram_b_we_o, 0);

    // Cycle-accurate latency/ordering vectors starting from an empty FIFO.
    vecs[0]  = '{1'b1, 32'hA5A5_0001, 1'b0, 1'b0, 32'h0,         1};
    vecs[1]  = '{1'b0, 32'h0,         1'b0, 1'b0, 32'h0,         1};
    vecs[2]  = '{1'b0, 32'h0,         1'b0, 1'b1, 32'hA5A5_0001, 1};
    vecs[3]  = '{1'b0, 32'h0,         1'b1, 1'b0, 32'h0,         0};
    vecs[4]  = '{1'b0, 32'h0,         1'b1, 1'b0, 32'h0,         0};
    vecs[5]  = '{1'b1, 32'h11,        1'b1, 1'b0, 32'h0,         1};
    vecs[6]  = '{1'b1, 32'h22,        1'b1, 1'b0, 32'h0,         2};
    vecs[7]  = '{1'b1, 32'h33,        1'b1, 1'b1, 32'h11,        3};
    vecs[8]  = '{1'b0, 32'h0,         1'b1, 1'b1, 32'h22,        2};
    vecs[9]  = '{1'b0, 32'h0,         1'b1, 1'b1, 32'h33,        1};
    vecs[10] = '{1'b0, 32'h0,         1'b1, 1'b0, 32'h0,         0};
    vecs[11] = '{1'b0, 32'h0,         1'b0, 1'b0, 32'h0,         0};
    for (int i = 0; i < 12; i++) begin
      applyStimulus(vecs[i].sv, vecs[i].sd, vecs[i].mr);
      checkOutput($sformatf("vec%0d_m_valid", i), m_valid_o, vecs[i].exp_mv);
      checkOutput($sformatf("vec%0d_count", i), count_o, vecs[i].exp_count);
      if (vecs[i].exp_mv) checkOutput($sformatf("vec%0d_m_data", i), m_data_o, vecs[i].exp_data);
    end

    // Fill to capacity, refuse an extra push, then pop and push while full.
    doReset();
    for (int i = 0; i < N; i++) applyStimulus(1'b1, DW'(i), 1'b0);
    checkOutput("full_s_ready", s_ready_o, 0);
    checkOutput("full_count", count_o, N);
    applyStimulus(1'b1, 32'hDEAD_BEEF, 1'b0);
    checkOutput("full_ignored_count", count_o, N);
    applyStimulus(1'b1, 32'd128, 1'b1);
    checkOutput("full_pop_count", count_o, N - 1);
    checkOutput("full_pop_head", m_data_o, 1);
    applyStimulus(1'b1, 32'd128, 1'b0);
    checkOutput("full_refill_count", count_o, N);
    drain("fill_drained");
    checkOutput("fill_pop_total", pop_total, N + 1);

    // Continuous streaming: one pop per cycle after the fill latency.
    doReset();
    for (int i = 0; i < 1000; i++) begin
      applyStimulus(1'b1, DW'(i + 1000), 1'b1);
      if (i >= 2) checkOutput("stream_m_valid", m_valid_o, 1);
      checkOutput("stream_count_bound", count_o <= 3, 1);
    end
    checkOutput("stream_pops", pop_total, 997);
    drain("stream_drained");

    // Random backpressure, enough traffic to wrap the pointers twice.
    doReset();
    for (int g = 0; g < 5000 && push_total < 300; g++) begin
      applyStimulus($urandom_range(0, 9) < 7, $urandom, $urandom_range(0, 9) < 4);
      checkOutput("rand_count_bound", count_o <= N, 1);
    end
    checkOutput("rand_push_total", push_total, 300);
    drain("rand_drained");
    checkOutput("rand_pop_total", pop_total, 300);

    // Reset with 50 entries queued.
    doReset();
    for (int i = 0; i < 50; i++) applyStimulus(1'b1, DW'(i + 500), 1'b0);
    checkOutput("pre_reset_count", count_o, 50);
    doReset();
    checkOutput("midrst_count", count_o, 0);
    checkOutput("midrst_m_valid", m_valid_o, 0);
    checkOutput("midrst_s_ready", s_ready_o, 1);
    applyStimulus(1'b1, 32'h1234, 1'b0);
    for (int i = 0; i < 10 && !m_valid_o; i++) applyStimulus(1'b0, '0, 1'b0);
    checkOutput("midrst_m_valid_after", m_valid_o, 1);
    checkOutput("midrst_m_data", m_data_o, 32'h1234);
    drain("midrst_drained");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
